// File: rtl/spike_gen_pkg.sv
// spike_gen_pkg: shared FSM state type, widths and saturation helper for spike_gen
package spike_gen_pkg;

   typedef enum logic {IDLE, REFRACT} state_t;

   localparam int WIDTH_DEF = 8;
   localparam int REFRACT_W = 4;

   function automatic logic [31:0] sat_max(input int w);
      return (w >= 32) ? '1 : (32'd1 << w) - 32'd1;
   endfunction

endpackage

// File: rtl/thresh_adapt.sv
// thresh_adapt: adaptive firing threshold (used when SPIKE_GEN_ADAPT_THRESH_EN is defined)
module thresh_adapt
   import spike_gen_pkg::*;
#(
   parameter int WIDTH        = WIDTH_DEF,
   parameter int ADAPT_STEP   = 16,
   parameter int DECAY_PERIOD = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] threshold_cfg,
   input  logic             spike,
   output logic [WIDTH-1:0] thr_eff
);

   localparam int DW = $clog2(DECAY_PERIOD + 1);
   localparam logic [DW-1:0] DLAST = DW'(DECAY_PERIOD - 1);
   localparam logic [WIDTH-1:0] TMAX = WIDTH'(sat_max(WIDTH));

   logic [DW-1:0] dcnt;
   logic [WIDTH:0] bumped;

   assign bumped = {1'b0, thr_eff} + (WIDTH + 1)'(ADAPT_STEP);

   // spike bumps the threshold (saturating) and restarts decay; otherwise snap up or decay toward base
   always_ff @(posedge clk) begin
      if (reset) begin
         thr_eff <= threshold_cfg;
         dcnt    <= '0;
      end else if (spike) begin
         thr_eff <= (bumped > {1'b0, TMAX}) ? TMAX : bumped[WIDTH-1:0];
         dcnt    <= '0;
      end else begin
         dcnt <= (dcnt == DLAST) ? '0 : dcnt + 1'b1;
         if (threshold_cfg > thr_eff)
            thr_eff <= threshold_cfg;
         else if (dcnt == DLAST && thr_eff != threshold_cfg)
            thr_eff <= thr_eff - 1'b1;
      end
   end

endmodule

// File: rtl/spike_gen.sv
// spike_gen: threshold/fire stage with refractory window and saturating spike counter (option: SPIKE_GEN_ADAPT_THRESH_EN)
module spike_gen
   import spike_gen_pkg::*;
#(
   parameter int WIDTH        = WIDTH_DEF,
   parameter int REFRACT_CYC  = 4,
   parameter int CNT_W        = 16,
   parameter int ADAPT_STEP   = 16,
   parameter int DECAY_PERIOD = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic [WIDTH-1:0] mem_state,
   input  logic [WIDTH-1:0] threshold_cfg,
   input  logic             clear_count,
   output logic             spike,
   output logic             refractory,
   output logic [CNT_W-1:0] spike_count,
   output logic [WIDTH-1:0] thr_eff
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(sat_max(CNT_W));
   localparam logic [REFRACT_W-1:0] REFR_LOAD = REFRACT_W'(REFRACT_CYC - 1);

   state_t state;
   logic [REFRACT_W-1:0] refr_cnt;
   logic fire_ok;

   assign fire_ok = enable && (mem_state >= thr_eff);

`ifdef SPIKE_GEN_ADAPT_THRESH_EN
   thresh_adapt #(
      .WIDTH       (WIDTH),
      .ADAPT_STEP  (ADAPT_STEP),
      .DECAY_PERIOD(DECAY_PERIOD)
   ) u_thresh_adapt (
      .clk          (clk),
      .reset        (reset),
      .threshold_cfg(threshold_cfg),
      .spike        (spike),
      .thr_eff      (thr_eff)
   );
`else
   logic unused_adapt;
   assign unused_adapt = ^{ADAPT_STEP, DECAY_PERIOD};

   // base threshold registered straight through
   always_ff @(posedge clk) thr_eff <= threshold_cfg;
`endif

   // the last window cycle doubles as the next firing decision, so the spike period equals REFRACT_CYC (min 2)
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         refr_cnt   <= '0;
         spike      <= 1'b0;
         refractory <= 1'b0;
      end else if (state == IDLE || (refr_cnt == '0 && !spike)) begin
         state      <= fire_ok ? REFRACT : IDLE;
         refr_cnt   <= fire_ok ? REFR_LOAD : '0;
         spike      <= fire_ok;
         refractory <= fire_ok;
      end else begin
         state      <= (refr_cnt == '0) ? IDLE : REFRACT;
         refr_cnt   <= (refr_cnt == '0) ? '0 : refr_cnt - 1'b1;
         spike      <= 1'b0;
         refractory <= (refr_cnt != '0);
      end
   end

   // saturating spike counter; clear wins over a coincident spike
   always_ff @(posedge clk) begin
      if (reset || clear_count)
         spike_count <= '0;
      else if (spike && spike_count != CNT_MAX)
         spike_count <= spike_count + 1'b1;
   end

endmodule

// File: tb/tb_spike_gen.sv
// tb_spike_gen: randomized and directed self-checking bench for spike_gen
module tb_spike_gen;

   localparam int R    = 4;
   localparam int CW   = 4;
   localparam int CMAX = 15;
   localparam int MINP = (R < 2) ? 2 : R;

   logic clk = 1'b0;
   logic reset = 1'b1, enable = 1'b0, clear_count = 1'b0;
   logic [7:0] mem_state = '0, threshold_cfg = '0, thr_eff;
   logic spike, refractory;
   logic [CW-1:0] spike_count;

   int vectors = 0, miscompares = 0;

   int edge_n = 0, last = 0, m_cnt = 0;
   bit have = 0, m_spike = 0, m_refr = 0;
   logic [7:0] m_thr = '0;

   spike_gen #(
      .WIDTH(8), .REFRACT_CYC(R), .CNT_W(CW), .ADAPT_STEP(16), .DECAY_PERIOD(8)
   ) dut (
      .clk(clk), .reset(reset), .enable(enable), .mem_state(mem_state),
      .threshold_cfg(threshold_cfg), .clear_count(clear_count),
      .spike(spike), .refractory(refractory), .spike_count(spike_count), .thr_eff(thr_eff)
   );

   always #5 clk = ~clk;

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1);
   end

   // drive one cycle of inputs and advance the time-based reference model at that edge
   task automatic step(input logic rs, input logic en, input logic [7:0] ms, input logic [7:0] cfg, input logic clr);
      bit fire;
      reset = rs; enable = en; mem_state = ms; threshold_cfg = cfg; clear_count = clr;
      @(posedge clk);
      edge_n++;
      if (rs) begin
         have = 0; m_spike = 0; m_refr = 0; m_cnt = 0;
      end else begin
         m_cnt = clr ? 0 : (m_spike && m_cnt < CMAX) ? m_cnt + 1 : m_cnt;
         fire = en && (ms >= m_thr) && (!have || edge_n - last >= MINP);
         if (fire) begin have = 1; last = edge_n; end
         m_spike = fire;
         m_refr = have && (edge_n - last < R);
      end
      m_thr = cfg;
      #1;
   endtask

   task automatic test_reset();
      step(1, 1, 200, 50, 0);
      step(1, 1, 200, 50, 0);
      vectors++;
      if ({spike, refractory, spike_count, thr_eff} !== {1'b0, 1'b0, 4'd0, 8'd50}) begin
         miscompares++;
         $display("FAIL reset_state: got %h want %h", {spike, refractory, spike_count, thr_eff}, {1'b0, 1'b0, 4'd0, 8'd50});
      end
   endtask

   task automatic test_basic_fire();
      step(1, 0, 0, 100, 0);
      step(0, 1, 99, 100, 0);
      vectors++;
      if (spike !== 1'b0) begin miscompares++; $display("FAIL fire_below: spike got %b want 0", spike); end
      step(0, 1, 100, 100, 0);
      vectors++;
      if (spike !== 1'b1) begin miscompares++; $display("FAIL fire_equal: spike got %b want 1", spike); end
      step(0, 0, 0, 100, 0);
      vectors++;
      if ({spike, spike_count} !== {1'b0, 4'd1}) begin
         miscompares++; $display("FAIL fire_count: got %h want %h", {spike, spike_count}, {1'b0, 4'd1});
      end
   endtask

   task automatic test_refractory();
      step(1, 0, 0, 100, 0);
      for (int i = 1; i <= 10; i++) begin
         step(0, 1, 200, 100, 0);
         vectors++;
         if ({spike, refractory} !== {(i % 4 == 1), m_refr}) begin
            miscompares++;
            $display("FAIL refract_cyc%0d: spike/refr got %b%b want %b%b", i, spike, refractory, (i % 4 == 1), m_refr);
         end
      end
      vectors++;
      if (spike_count !== 4'd3) begin miscompares++; $display("FAIL refract_count: got %0d want 3", spike_count); end
   endtask

   task automatic test_enable_reset();
      step(1, 0, 0, 100, 0);
      step(0, 1, 200, 100, 0);
      for (int j = 0; j < 6; j++) begin
         step(0, 0, 200, 100, 0);
         vectors++;
         if ({spike, refractory} !== {1'b0, j < 3}) begin
            miscompares++;
            $display("FAIL enable_off_%0d: spike/refr got %b%b want 0%b", j, spike, refractory, j < 3);
         end
      end
      step(1, 0, 0, 100, 0);
      step(0, 1, 200, 100, 0);
      step(0, 1, 200, 100, 0);
      step(1, 1, 200, 100, 0);
      vectors++;
      if ({spike, refractory, spike_count, thr_eff} !== {1'b0, 1'b0, 4'd0, 8'd100}) begin
         miscompares++;
         $display("FAIL reset_mid_window: got %h want %h", {spike, refractory, spike_count, thr_eff}, {1'b0, 1'b0, 4'd0, 8'd100});
      end
   endtask

   task automatic test_boundaries();
      int n = 0;
      step(1, 0, 0, 0, 0);
      for (int i = 0; i < 9; i++) begin
         step(0, 1, 0, 0, 0);
         n += spike;
      end
      vectors++;
      if (n != 3) begin miscompares++; $display("FAIL thr_zero: spikes got %0d want 3", n); end
      step(1, 0, 0, 255, 0);
      step(0, 1, 255, 255, 0);
      vectors++;
      if (spike !== 1'b1) begin miscompares++; $display("FAIL thr_max: spike got %b want 1", spike); end
   endtask

   task automatic test_saturation();
      step(1, 0, 0, 0, 0);
      for (int i = 0; i < 81; i++) begin
         step(0, 1, 0, 0, 0);
         vectors++;
         if ({spike, refractory, spike_count} !== {m_spike, m_refr, 4'(m_cnt)}) begin
            miscompares++;
            $display("FAIL sat_cyc%0d: got %h want %h", i, {spike, refractory, spike_count}, {m_spike, m_refr, 4'(m_cnt)});
         end
      end
      vectors++;
      if (spike_count !== 4'd15) begin miscompares++; $display("FAIL sat_hold: got %0d want 15", spike_count); end
   endtask

   task automatic test_clear_collision();
      int k = 0;
      step(1, 0, 0, 0, 0);
      while (!(m_spike && m_cnt == 7) && k < 100) begin
         step(0, 1, 0, 0, 0);
         k++;
      end
      vectors++;
      if (k >= 100) begin
         miscompares++; $display("FAIL clear_setup: got timeout want spike with count 7");
      end else begin
         vectors++;
         if ({spike, spike_count} !== {1'b1, 4'd7}) begin
            miscompares++; $display("FAIL clear_pre: got %h want %h", {spike, spike_count}, {1'b1, 4'd7});
         end
         step(0, 1, 0, 0, 1);
         vectors++;
         if (spike_count !== 4'd0) begin miscompares++; $display("FAIL clear_collide: got %0d want 0", spike_count); end
         step(0, 1, 0, 0, 0);
         vectors++;
         if (spike_count !== 4'd0) begin miscompares++; $display("FAIL clear_after: got %0d want 0", spike_count); end
      end
   endtask

   task automatic test_random();
      logic [7:0] cfgs [5] = '{8'd0, 8'd50, 8'd100, 8'd200, 8'd255};
      logic [7:0] cfg;
      step(1, 0, 0, 100, 0);
      for (int i = 0; i < 500; i++) begin
         cfg = ($urandom_range(3) == 0) ? 8'($urandom) : cfgs[$urandom_range(4)];
         step($urandom_range(49) == 0, $urandom_range(4) != 0, 8'($urandom), cfg, $urandom_range(29) == 0);
         vectors++;
         if ({spike, refractory, spike_count, thr_eff} !== {m_spike, m_refr, 4'(m_cnt), m_thr}) begin
            miscompares++;
            $display("FAIL random_%0d: got %h want %h", i, {spike, refractory, spike_count, thr_eff}, {m_spike, m_refr, 4'(m_cnt), m_thr});
         end
      end
   endtask

   task automatic test_adapt();
      step(1, 0, 0, 100, 0);
      step(0, 1, 200, 100, 0);
      step(0, 1, 0, 100, 0);
      vectors++;
      if (thr_eff !== 8'd116) begin miscompares++; $display("FAIL adapt_bump: got %0d want 116", thr_eff); end
      for (int i = 0; i < 8; i++) step(0, 1, 0, 100, 0);
      vectors++;
      if (thr_eff !== 8'd115) begin miscompares++; $display("FAIL adapt_decay1: got %0d want 115", thr_eff); end
      for (int i = 0; i < 128; i++) step(0, 1, 0, 100, 0);
      vectors++;
      if (thr_eff !== 8'd100) begin miscompares++; $display("FAIL adapt_floor: got %0d want 100", thr_eff); end
      step(0, 1, 0, 250, 0);
      vectors++;
      if (thr_eff !== 8'd250) begin miscompares++; $display("FAIL adapt_snap: got %0d want 250", thr_eff); end
      step(0, 1, 255, 250, 0);
      step(0, 1, 0, 250, 0);
      vectors++;
      if (thr_eff !== 8'd255) begin miscompares++; $display("FAIL adapt_sat: got %0d want 255", thr_eff); end
   endtask

   initial begin
      test_reset();
`ifdef SPIKE_GEN_ADAPT_THRESH_EN
      test_adapt();
`else
      test_basic_fire();
      test_refractory();
      test_enable_reset();
      test_boundaries();
      test_saturation();
      test_clear_collision();
      test_random();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/spike_gen.md
Name: spike_gen

Overview:
- Threshold/fire stage directly downstream of the leaky-integrate neuron.
- Compares the neuron's 8-bit membrane state against a threshold and emits a one-cycle spike pulse.
- The spike is fed back to the neuron's spike input, which suppresses the leak term on the next update.
- Enforces a refractory window after each spike and keeps a saturating spike counter for readout.

Parameters:
- WIDTH, 8, membrane state and threshold width.
- REFRACT_CYC, 4, refractory length in cycles, including the spike cycle; legal range 1..15.
- CNT_W, 16, spike counter width.
- ADAPT_STEP, 16, threshold increment per spike; used only with the optional feature.
- DECAY_PERIOD, 8, cycles between 1-LSB threshold decay steps; used only with the optional feature.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  permits new firing decisions.
- mem_state  input  WIDTH  membrane state from the neuron (its registered state output).
- threshold_cfg  input  WIDTH  base firing threshold, unsigned.
- clear_count  input  1  synchronous clear of spike_count.
- spike  output  1  registered one-cycle fire pulse; drives the neuron's spike input.
- refractory  output  1  high while in REFRACT.
- spike_count  output  CNT_W  saturating count of spikes.
- thr_eff  output  WIDTH  effective threshold currently in use.

Behaviour:
- Reset (clk edge with reset=1):
  - fsm=IDLE, refr_cnt=0, spike=0, refractory=0, spike_count=0.
  - thr_eff=threshold_cfg; decay counter=0.
  - Reset mid-refractory aborts the window immediately.
- FSM states are IDLE and REFRACT.
- IDLE, when enable=1 and mem_state >= thr_eff (unsigned compare) at edge N:
  - At N+1: spike=1, refractory=1, fsm=REFRACT, refr_cnt=REFRACT_CYC-1.
  - Latency from the qualifying sample to the spike is exactly 1 cycle.
- IDLE, otherwise: spike=0, refractory=0.
- REFRACT:
  - spike=0 after its first cycle; mem_state is ignored.
  - If refr_cnt==0, go to IDLE (refractory=0 next cycle); else refr_cnt decrements.
  - Total refractory=1 duration is REFRACT_CYC cycles.
  - With REFRACT_CYC=1, consecutive spikes are possible only every other cycle.
  - Minimum spike period is max(2, REFRACT_CYC) cycles.
- Enable:
  - enable=0 blocks only new firing; an in-progress refractory window still counts down.
- Threshold edge cases:
  - threshold_cfg=0: fires on every IDLE cycle while enable=1.
  - threshold_cfg=255 with mem_state=255: fires, since the compare is >=.
- threshold_cfg is sampled continuously; a change takes effect on the next compare (feature off).
- spike_count:
  - Increments by 1 on each cycle spike=1.
  - Saturates at 2^CNT_W-1, with no wrap.
  - clear_count=1 sets it to 0 at the next edge; clear has priority over a simultaneous spike, and that spike is not counted.
- All outputs are registered; no combinational path from input to output.

Optional Feature:
- Macro: SPIKE_GEN_ADAPT_THRESH_EN
- Defined (adaptive threshold):
  - On each spike, thr_eff <= min(thr_eff + ADAPT_STEP, 255).
  - Every DECAY_PERIOD cycles in which no spike occurs, thr_eff moves 1 LSB toward threshold_cfg, never past it.
  - If threshold_cfg > thr_eff, thr_eff snaps to threshold_cfg.
  - A spike and a decay tick in the same cycle: the spike increment wins and the decay counter restarts.
- Undefined: thr_eff = threshold_cfg registered each cycle; ADAPT_STEP and DECAY_PERIOD are unused.

Decomposition:
- Package spike_gen_pkg holds:
  - FSM state typedef (IDLE, REFRACT).
  - WIDTH_DEF=8 and REFRACT_W=4 constants.
  - Saturation-max constant function for counters.
- One natural sub-module, thresh_adapt:
  - Owns thr_eff and the decay counter.
  - Instantiated only under SPIKE_GEN_ADAPT_THRESH_EN; otherwise a register from threshold_cfg is used.

Test Plan:
- Basic fire: threshold_cfg=100, enable=1, mem_state steps 99 then 100 -> no spike on 99; spike=1 exactly one cycle after the 100 sample; spike_count=1.
- Refractory: REFRACT_CYC=4, mem_state held at 200, threshold 100 -> spikes at cycles 1, 5, 9; refractory high 4 cycles each; spike_count=3 after 10 cycles.
- Enable/reset mid-window: fire, then enable=0 -> window still completes, no new spike. Separately, reset during REFRACT cycle 2 -> all outputs 0 next cycle and spike_count=0.
- Boundaries:
  - threshold_cfg=0 with mem_state=0 -> periodic spikes.
  - threshold_cfg=255 with mem_state=255 -> spike.
  - CNT_W=4, run 20 spikes -> spike_count sticks at 15.
- Clear collision: clear_count=1 on the same cycle spike=1 with spike_count=7 -> spike_count=0, not 1.
- Adaptive threshold (macro on, ADAPT_STEP=16, DECAY_PERIOD=8, threshold_cfg=100):
  - One spike -> thr_eff=116.
  - After 8 spike-free cycles -> 115; after 128 more spike-free cycles -> 100 and holds.
  - With thr_eff=250, a spike -> 255.
